// File: rtl/eightbit_divider_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock,
// using a single eightbit_subtractor for the trial subtraction.

module eightbit_subtractor (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       cout,
  output logic       overflow
);
  logic [8:0] sum;

  // A - B as A + ~B + 1; cout = 1 means no borrow
  assign sum      = {1'b0, a} + {1'b0, ~b} + 9'd1;
  assign diff     = sum[7:0];
  assign cout     = sum[8];
  assign overflow = (a[7] ^ b[7]) & (a[7] ^ sum[7]);
endmodule

module eightbit_divider_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] r_reg, q_reg, d_reg;
  logic [2:0] cnt;

  logic [8:0] s;
  logic [7:0] sub_diff;
  logic       sub_cout;
  logic       unused_sub_ovf;
  logic       take;
  logic [7:0] r_next, q_next;

  assign s = {r_reg, q_reg[7]};

  eightbit_subtractor u_sub (
    .a        (s[7:0]),
    .b        (d_reg),
    .diff     (sub_diff),
    .cout     (sub_cout),
    .overflow (unused_sub_ovf)
  );

  // With S[8] set the true difference is below D, so the low 8 bits are exact
  assign take   = s[8] | sub_cout;
  assign r_next = take ? sub_diff : s[7:0];
  assign q_next = {q_reg[6:0], take};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor != '0) ? RUN : DONE;
      RUN:  if (cnt == 3'd7) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Result outputs only move on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_reg <= '0;
              q_reg <= dividend;
              d_reg <= divisor;
              cnt   <= '0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_eightbit_divider_seq.sv
// Self-checking bench for eightbit_divider_seq against integer / and %.

module tb_eightbit_divider_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int unsigned total = 0;
  int unsigned bad   = 0;

  eightbit_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one division from IDLE and check results, latency and stability.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  eq, er, pq, pr;
    logic        edz, pz, seen, stable;
    int unsigned exp_lat, exp_busy, cyc, nbusy;
    string       tg;
    edz      = (b == 8'd0);
    eq       = edz ? 8'hFF : 8'(a / b);
    er       = edz ? a : 8'(a % b);
    exp_lat  = edz ? 1 : 9;
    exp_busy = edz ? 0 : 8;
    tg = $sformatf("%0d/%0d", a, b);
    @(negedge clk);
    pq = quotient; pr = remainder; pz = div_by_zero;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    cyc = 0; nbusy = 0; seen = 1'b0; stable = 1'b1;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        nbusy++;
        if (quotient !== pq || remainder !== pr || div_by_zero !== pz) stable = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check({tg, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tg, " quotient"},    32'(quotient),    32'(eq));
      check({tg, " remainder"},   32'(remainder),   32'(er));
      check({tg, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
      check({tg, " latency"},     cyc,              exp_lat);
      check({tg, " busy_cycles"}, nbusy,            exp_busy);
      check({tg, " stable"},      32'(stable),      32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ndone, done_cyc;
    logic        stable;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #23;
    check("rst busy",        32'(busy),        32'd0);
    check("rst done",        32'(done),        32'd0);
    check("rst quotient",    32'(quotient),    32'd0);
    check("rst remainder",   32'(remainder),   32'd0);
    check("rst div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(8'd200, 8'd7);
    do_div(8'd255, 8'd1);
    do_div(8'd13,  8'd200);
    do_div(8'd0,   8'd5);
    do_div(8'd255, 8'd255);
    do_div(8'd255, 8'd129);
    do_div(8'd254, 8'd128);
    do_div(8'd200, 8'd150);
    do_div(8'd77,  8'd0);
    do_div(8'd9,   8'd3);

    // start pulses during RUN (cycle 3) and DONE (cycle 9) must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd9;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; done_cyc = 0; stable = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin ndone++; done_cyc = 32'(c); end
      if (busy && (quotient !== 8'd3 || remainder !== 8'd0)) stable = 1'b0;
      if (c == 3 || c == 9) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_start ndone",     ndone,            32'd1);
    check("busy_start done_cyc",  done_cyc,         32'd9);
    check("busy_start quotient",  32'(quotient),    32'd11);
    check("busy_start remainder", 32'(remainder),   32'd1);
    check("busy_start stable",    32'(stable),      32'd1);

    // start held high re-triggers once per return to IDLE
    @(negedge clk);
    start = 1'b1; dividend = 8'd20; divisor = 8'd3;
    ndone = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check("held_start ndone",     ndone,          32'd2);
    check("held_start quotient",  32'(quotient),  32'd6);
    check("held_start remainder", 32'(remainder), 32'd2);
    repeat (12) @(negedge clk);

    // reset in the 4th busy cycle aborts the operation
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",        32'(busy),        32'd0);
    check("abort done",        32'(done),        32'd0);
    check("abort quotient",    32'(quotient),    32'd0);
    check("abort remainder",   32'(remainder),   32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort no_activity", ndone, 32'd0);
    do_div(8'd81, 8'd9);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (i % 8 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      do_div(a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
